// File: rtl/vga_pkg.sv
// Shared VGA timing constants, address widths and sync receiver state type.
// Defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_pkg;

   localparam int unsigned VGA_H_PULSE  = 96;
   localparam int unsigned VGA_H_BP     = 48;
   localparam int unsigned VGA_H_ACTIVE = 640;
   localparam int unsigned VGA_H_FP     = 16;

   localparam int unsigned VGA_V_PULSE  = 2;
   localparam int unsigned VGA_V_BP     = 33;
   localparam int unsigned VGA_V_ACTIVE = 480;
   localparam int unsigned VGA_V_FP     = 10;

   localparam int unsigned ADDR_X_WIDTH = 10;
   localparam int unsigned ADDR_Y_WIDTH = 9;

   typedef enum logic [1:0] {
      RX_SEARCH,
      RX_MEASURE,
      RX_LOCKED
   } rx_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Samples one active-low sync line and flags its falling edge.
// Ports: clk, reset_n (async, active-low), sync_i (raw sync), fall_o (edge pulse).
module vga_sync_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic sync_i,
   output logic fall_o
);

   logic sync_q;

   // Idle level of a sync line is high, so reset to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= 1'b1;
      else          sync_q <= sync_i;
   end

   assign fall_o = sync_q & ~sync_i;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: recovers pixel coordinates from hs/vs and monitors timing.
// Ports: clk, reset_n, vga_hs, vga_vs in; pix_valid/x/y, frame_start, locked, h_err, v_err out.
module vga_sync_receiver
   import vga_pkg::*;
#(
   parameter int unsigned H_PULSE  = VGA_H_PULSE,
   parameter int unsigned H_BP     = VGA_H_BP,
   parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
   parameter int unsigned H_FP     = VGA_H_FP,
   parameter int unsigned V_PULSE  = VGA_V_PULSE,
   parameter int unsigned V_BP     = VGA_V_BP,
   parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
   parameter int unsigned V_FP     = VGA_V_FP
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    vga_hs,
   input  logic                    vga_vs,
   output logic                    pix_valid,
   output logic [ADDR_X_WIDTH-1:0] pix_x,
   output logic [ADDR_Y_WIDTH-1:0] pix_y,
   output logic                    frame_start,
   output logic                    locked,
   output logic                    h_err,
   output logic                    v_err
);

   localparam int unsigned H_TOTAL = H_PULSE + H_BP + H_ACTIVE + H_FP;
   localparam int unsigned V_TOTAL = V_PULSE + V_BP + V_ACTIVE + V_FP;
   localparam int unsigned H_SAT   = 2 * H_TOTAL - 1;
   localparam int unsigned V_SAT   = 2 * V_TOTAL - 1;
   localparam int unsigned HW      = $clog2(2 * H_TOTAL);
   localparam int unsigned VW      = $clog2(2 * V_TOTAL);
   localparam int unsigned H_OFF   = H_PULSE + H_BP;
   localparam int unsigned V_OFF   = V_PULSE + V_BP;

   logic          hs_fall, vs_fall;
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic          vs_pend_q, vs_pend_d;
   logic          seen_q;
   logic          skip_q;
   rx_state_t     state_q;

   logic frame_ev, line_err, h_to, f_err, v_to;
   logic h_err_c, v_err_c, err, hvis, vvis, lk, vis;

   vga_sync_edge u_hs_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .sync_i  (vga_hs),
      .fall_o  (hs_fall)
   );

   vga_sync_edge u_vs_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .sync_i  (vga_vs),
      .fall_o  (vs_fall)
   );

   always_comb begin
      // A vsync edge is only acted on at the next line start.
      frame_ev = hs_fall & (vs_pend_q | vs_fall);
      line_err = hs_fall & (state_q != RX_SEARCH) & ~skip_q
               & (h_cnt_q != HW'(H_TOTAL - 1));
      // Timeouts fire on the step into saturation, so they pulse once.
      h_to     = ~hs_fall & (h_cnt_q == HW'(H_SAT - 1));
      f_err    = frame_ev & (v_cnt_q != VW'(V_TOTAL - 1));
      v_to     = hs_fall & ~frame_ev & (v_cnt_q == VW'(V_SAT - 1));
      h_err_c  = seen_q & (line_err | h_to);
      v_err_c  = seen_q & (f_err | v_to);
      err      = h_err_c | v_err_c;

      h_cnt_d = h_cnt_q;
      if (hs_fall)                    h_cnt_d = '0;
      else if (h_cnt_q != HW'(H_SAT)) h_cnt_d = h_cnt_q + HW'(1);

      v_cnt_d = v_cnt_q;
      if (frame_ev)                                v_cnt_d = '0;
      else if (hs_fall && v_cnt_q != VW'(V_SAT))   v_cnt_d = v_cnt_q + VW'(1);

      vs_pend_d = frame_ev ? 1'b0 : (vs_pend_q | vs_fall);

      hvis = (h_cnt_q >= HW'(H_OFF)) && (h_cnt_q < HW'(H_OFF + H_ACTIVE));
      vvis = (v_cnt_q >= VW'(V_OFF)) && (v_cnt_q < VW'(V_OFF + V_ACTIVE));
      lk   = (state_q == RX_LOCKED);
      vis  = hvis & vvis & lk;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         vs_pend_q   <= 1'b0;
         seen_q      <= 1'b0;
         skip_q      <= 1'b0;
         state_q     <= RX_SEARCH;
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         h_err       <= 1'b0;
         v_err       <= 1'b0;
      end else begin
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         vs_pend_q   <= vs_pend_d;
         seen_q      <= seen_q | hs_fall;
         h_err       <= h_err_c;
         v_err       <= v_err_c;
         locked      <= lk;
         pix_valid   <= vis;
         pix_x       <= vis ? ADDR_X_WIDTH'(h_cnt_q - HW'(H_OFF)) : '0;
         pix_y       <= vis ? ADDR_Y_WIDTH'(v_cnt_q - VW'(V_OFF)) : '0;
         frame_start <= lk & (h_cnt_q == HW'(H_OFF))
                      & (v_cnt_q == VW'(V_OFF));
         if (hs_fall) skip_q <= 1'b0;
         unique case (state_q)
            RX_SEARCH: begin
               // The first measured line may follow a partial one.
               if (frame_ev) begin
                  state_q <= RX_MEASURE;
                  skip_q  <= 1'b1;
               end
            end
            RX_MEASURE: begin
               if (err)           state_q <= RX_SEARCH;
               else if (frame_ev) state_q <= RX_LOCKED;
            end
            RX_LOCKED: begin
               if (err) state_q <= RX_SEARCH;
            end
            default: state_q <= RX_SEARCH;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed bench for vga_sync_receiver: 800-clock lines, short 6-line frames.
// Checks lock, pixel window and latency, line/frame errors and async reset.
`timescale 1ns/1ps
module tb_vga_sync_receiver;

   localparam int HP = 96, HB = 48, HA = 640, HF = 16;
   localparam int HT = HP + HB + HA + HF;
   localparam int VP = 2, VB = 1, VA = 2, VF = 1;
   localparam int VT = VP + VB + VA + VF;
   localparam int VOFF = VP + VB;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       vga_hs, vga_vs;
   logic       pix_valid, frame_start, locked, h_err, v_err;
   logic [9:0] pix_x;
   logic [8:0] pix_y;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int line_edge = 0;
   int cur_v = 0;
   int gen_h = -1;
   int gen_v = -1;
   int ledge [16];
   bit mon_en = 1'b0;

   int pv_cnt = 0;
   int fs_cnt = 0;
   int pix_bad = 0;
   int herr_q[$], verr_q[$], lrise_q[$], lfall_q[$], pvr_q[$], pvf_q[$];

   vga_sync_receiver #(
      .V_PULSE  (VP),
      .V_BP     (VB),
      .V_ACTIVE (VA),
      .V_FP     (VF)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .vga_hs      (vga_hs),
      .vga_vs      (vga_vs),
      .pix_valid   (pix_valid),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .frame_start (frame_start),
      .locked      (locked),
      .h_err       (h_err),
      .v_err       (v_err)
   );

   always #20 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, got, exp);
      end
   endtask

   // One line: hsync low for HP clocks from position 0.
   task automatic line(input int len, input bit vs_low);
      for (int c = 0; c < len; c++) begin
         @(posedge clk);
         #1;
         if (c == 0) line_edge = cyc + 1;
         vga_hs = (c < HP) ? 1'b0 : 1'b1;
         vga_vs = vs_low ? 1'b0 : 1'b1;
         gen_h  = c;
         gen_v  = cur_v;
      end
   endtask

   task automatic frame(input int nl, input int short_l);
      for (int l = 0; l < nl; l++) begin
         cur_v = l;
         line((l == short_l) ? HT - 1 : HT, l < VP);
         ledge[l] = line_edge;
      end
   endtask

   // Monitor: event logs plus a pixel model delayed two samples from the driver.
   initial begin
      int p1h, p1v, p2h, p2v, ex, ey;
      bit ev, efs, lk_prev, pv_prev;
      p1h = -1; p1v = -1; p2h = -1; p2v = -1;
      lk_prev = 1'b0; pv_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (pix_valid === 1'b1) pv_cnt++;
         if (frame_start === 1'b1) fs_cnt++;
         if (h_err === 1'b1) herr_q.push_back(cyc);
         if (v_err === 1'b1) verr_q.push_back(cyc);
         if (locked === 1'b1 && !lk_prev) lrise_q.push_back(cyc);
         if (locked !== 1'b1 && lk_prev) lfall_q.push_back(cyc);
         if (pix_valid === 1'b1 && !pv_prev) pvr_q.push_back(cyc);
         if (pix_valid !== 1'b1 && pv_prev) pvf_q.push_back(cyc);
         lk_prev = (locked === 1'b1);
         pv_prev = (pix_valid === 1'b1);
         if (mon_en) begin
            ev  = (p2h >= HP + HB) && (p2h < HP + HB + HA)
               && (p2v >= VOFF) && (p2v < VOFF + VA);
            ex  = ev ? p2h - (HP + HB) : 0;
            ey  = ev ? p2v - VOFF : 0;
            efs = (p2h == HP + HB) && (p2v == VOFF);
            if (pix_valid !== ev || pix_x !== 10'(ex) ||
                pix_y !== 9'(ey) || frame_start !== efs)
               pix_bad++;
         end
         p2h = p1h; p2v = p1v;
         p1h = gen_h; p1v = gen_v;
      end
   end

   initial begin
      int nh, nv, nr, nf, npr, npf, npv, nfs, e0;
      reset_n = 1'b0;
      vga_hs  = 1'b1;
      vga_vs  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", 32'({pix_valid, frame_start, locked,
                             h_err, v_err, pix_x, pix_y}), 0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Frame A: first frame event enters measurement.
      frame(VT, -1);
      chk("lock_after_1st_event", 32'(locked), 0);

      // Frame B: second event locks; full pixel window checked.
      nh = herr_q.size(); nv = verr_q.size(); nr = lrise_q.size();
      npr = pvr_q.size(); npf = pvf_q.size();
      npv = pv_cnt; nfs = fs_cnt;
      mon_en = 1'b1;
      frame(VT, -1);
      mon_en = 1'b0;
      chk("lock_rise_cyc", lrise_q[nr], ledge[0] + 1);
      chk("pix_valid_count", pv_cnt - npv, VA * HA);
      chk("frame_start_count", fs_cnt - nfs, 1);
      chk("nominal_h_err", herr_q.size() - nh, 0);
      chk("nominal_v_err", verr_q.size() - nv, 0);
      chk("pixel_model", pix_bad, 0);
      chk("latency_first_px", pvr_q[npr] - ledge[VOFF], 145);
      chk("latency_last_px", pvf_q[npf] - 1 - ledge[VOFF], 784);

      // Frame C: 799-clock line 2, error at start of line 3.
      nh = herr_q.size(); nf = lfall_q.size(); npv = pv_cnt;
      frame(VT, 2);
      chk("short_h_err_count", herr_q.size() - nh, 1);
      chk("short_h_err_cyc", herr_q[nh], ledge[3]);
      chk("short_lock_drop", lfall_q[nf], ledge[3] + 1);
      chk("short_no_pixels", pv_cnt - npv, 0);

      // Frame D then start of E: two clean events relock.
      nh = herr_q.size(); nv = verr_q.size();
      frame(VT, -1);
      chk("relock_after_one", 32'(locked), 0);
      chk("relock_d_errs", (herr_q.size() - nh) + (verr_q.size() - nv), 0);
      nr = lrise_q.size();
      frame(2, -1);
      e0 = ledge[0];
      chk("relock_rise_cyc", lrise_q[nr], e0 + 1);
      chk("relock_locked", 32'(locked), 1);

      // Missing hsync: one falling edge then high for 1700 clocks.
      nh = herr_q.size(); nf = lfall_q.size();
      cur_v = 2;
      line(1700, 1'b0);
      chk("timeout_h_err_count", herr_q.size() - nh, 1);
      chk("timeout_h_err_cyc", herr_q[nh], line_edge + 1599);
      chk("timeout_lock_drop", lfall_q[nf], line_edge + 1600);
      chk("timeout_locked", 32'(locked), 0);

      // Frames F, G: hs/vs fall together at each frame event.
      frame(VT, -1);
      nh = herr_q.size(); nv = verr_q.size();
      frame(3, -1);
      chk("same_cycle_errs", (herr_q.size() - nh) + (verr_q.size() - nv), 0);
      chk("same_cycle_locked", 32'(locked), 1);

      // Async reset in the middle of visible line 3.
      cur_v = 3;
      line(300, 1'b0);
      chk("pre_reset_valid", 32'(pix_valid), 1);
      #3 reset_n = 1'b0;
      #1;
      chk("async_reset_outs", 32'({pix_valid, frame_start, locked,
                                   h_err, v_err, pix_x, pix_y}), 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      frame(VT, -1);
      chk("post_reset_one_event", 32'(locked), 0);
      frame(VT, -1);
      chk("post_reset_two_events", 32'(locked), 1);

      // Bad frame: 5 lines, error at the following frame event.
      frame(VT - 1, -1);
      nv = verr_q.size(); nf = lfall_q.size();
      cur_v = 0;
      line(HT, 1'b1);
      chk("bad_frame_v_err_count", verr_q.size() - nv, 1);
      chk("bad_frame_v_err_cyc", verr_q[nv], line_edge);
      chk("bad_frame_lock_drop", lfall_q[nf], line_edge + 1);
      chk("bad_frame_locked", 32'(locked), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
